// File: rtl/pipe_step_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_step_ctrl
//
// Run/step controller that sits between the board push-button and the
// pipeline's global clock-enable. The raw button is synchronised and
// debounced, and each clean press drives a small HALTED/RUNNING FSM that
// gates the pipeline in one of four modes:
//   0 FREE   - pipeline always enabled, button and breakpoints ignored
//   1 SINGLE - each press lets exactly one instruction retire
//   2 STEP_N - each press lets i_step_count instructions retire (0 -> 1)
//   3 RUN_BP - each press runs until an enabled breakpoint PC retires
// Retired instructions are counted in every mode.
//
// Ports:
//   i_clk           clock, all state on the rising edge
//   i_rst_n         synchronous active-low reset
//   i_btn           raw asynchronous push-button, high = pressed
//   i_mode          run mode (see above)
//   i_step_count    burst length for STEP_N
//   i_bp_en         per-comparator breakpoint enable
//   i_bp_addr       breakpoint PCs, comparator k at [k*XLEN +: XLEN]
//   i_retire_valid  pipeline retires an instruction this cycle
//   i_retire_pc     PC of the retiring instruction
//   o_pipe_en       pipeline clock-enable
//   o_halted        FSM halted while not in FREE mode
//   o_bp_hit        sticky per-comparator breakpoint-hit flags
//   o_steps_left    remaining steps of the current STEP_N burst
//   o_retire_cnt    wrapping retired-instruction counter
// ---------------------------------------------------------------------------
module pipe_step_ctrl #(
    parameter int XLEN            = 32,
    parameter int NUM_BP          = 2,
    parameter int STEP_W          = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_btn,
    input  logic [1:0]               i_mode,
    input  logic [STEP_W-1:0]        i_step_count,
    input  logic [NUM_BP-1:0]        i_bp_en,
    input  logic [NUM_BP*XLEN-1:0]   i_bp_addr,
    input  logic                     i_retire_valid,
    input  logic [XLEN-1:0]          i_retire_pc,
    output logic                     o_pipe_en,
    output logic                     o_halted,
    output logic [NUM_BP-1:0]        o_bp_hit,
    output logic [STEP_W-1:0]        o_steps_left,
    output logic [CNT_W-1:0]         o_retire_cnt
);

    typedef enum logic [1:0] {
        MODE_FREE   = 2'd0,
        MODE_SINGLE = 2'd1,
        MODE_STEP_N = 2'd2,
        MODE_RUN_BP = 2'd3
    } mode_e;

    typedef enum logic {
        ST_HALTED  = 1'b0,
        ST_RUNNING = 1'b1
    } state_e;

    // The debounce counter only ever needs to reach DEBOUNCE_CYCLES-1.
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic              sync1_q,     sync1_d;
    logic              sync2_q,     sync2_d;
    logic              db_level_q,  db_level_d;
    logic [DB_W-1:0]   db_cnt_q,    db_cnt_d;
    logic              db_prev_q,   db_prev_d;
    state_e            state_q,     state_d;
    logic [NUM_BP-1:0] bp_hit_q,    bp_hit_d;
    logic [STEP_W-1:0] steps_q,     steps_d;
    logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;

    logic              press;
    logic              pipe_en;
    logic              retire_ok;
    logic              bp_mode;
    logic [NUM_BP-1:0] bp_match;
    logic [STEP_W-1:0] step_load;

    // -----------------------------------------------------------------------
    // Button front end: two-flop synchroniser followed by a level debouncer.
    // The debouncer only accepts a new level after the synchronised input
    // has disagreed with it for DEBOUNCE_CYCLES consecutive samples; any
    // agreeing sample restarts the count.
    // -----------------------------------------------------------------------
    always_comb begin
        sync1_d    = i_btn;
        sync2_d    = sync1_q;
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        db_prev_d  = db_level_q;
        if (sync2_q != db_level_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_level_d = sync2_q;
                db_cnt_d   = '0;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    // A press is the rising edge of the debounced level; releases are
    // deliberately not events.
    assign press = db_level_q & ~db_prev_q;

    // -----------------------------------------------------------------------
    // Pipeline gating and retire qualification. The enable is combinational
    // on i_mode so that entering or leaving FREE takes effect immediately,
    // without waiting for the FSM.
    // -----------------------------------------------------------------------
    assign pipe_en   = (i_mode == MODE_FREE) | (state_q == ST_RUNNING);
    assign retire_ok = i_retire_valid & pipe_en;
    assign bp_mode   = (i_mode == MODE_STEP_N) | (i_mode == MODE_RUN_BP);
    assign step_load = (i_step_count == '0) ? STEP_W'(1) : i_step_count;

    // Breakpoint comparators: only a counted retire in STEP_N or RUN_BP can
    // match, so FREE and SINGLE never raise a hit.
    always_comb begin
        bp_match = '0;
        for (int k = 0; k < NUM_BP; k++) begin
            bp_match[k] = i_bp_en[k] & retire_ok & bp_mode &
                          (i_retire_pc == i_bp_addr[k*XLEN +: XLEN]);
        end
    end

    // -----------------------------------------------------------------------
    // Run/step FSM next-state logic. Several halting causes can coincide on
    // one edge (last step, breakpoint, press); they all converge on HALTED
    // while each still applies its own side effect, so a coincident retire
    // is counted, decrements the burst, and records its breakpoint.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        steps_d  = steps_q;
        bp_hit_d = bp_hit_q;

        if (i_mode == MODE_FREE) begin
            state_d = ST_HALTED;
        end else if (state_q == ST_HALTED) begin
            if (press) begin
                state_d  = ST_RUNNING;
                bp_hit_d = '0;
                if (i_mode == MODE_STEP_N) begin
                    steps_d = step_load;
                end
            end
        end else begin
            if (retire_ok && (i_mode == MODE_STEP_N)) begin
                // Saturate at zero in case the burst was entered by a mode
                // switch without a reload.
                if (steps_q != '0) begin
                    steps_d = steps_q - STEP_W'(1);
                end
                if (steps_q <= STEP_W'(1)) begin
                    state_d = ST_HALTED;
                end
            end
            if (retire_ok && (i_mode == MODE_SINGLE)) begin
                state_d = ST_HALTED;
            end
            if (|bp_match) begin
                state_d  = ST_HALTED;
                bp_hit_d = bp_hit_q | bp_match;
            end
            if (press) begin
                state_d = ST_HALTED;
            end
        end
    end

    // Retire counter wraps naturally at 2^CNT_W.
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (retire_ok) begin
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // All state registers. Reset has priority, so a reset edge aborts any
    // burst and never counts a retire.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            db_level_q   <= 1'b0;
            db_cnt_q     <= '0;
            db_prev_q    <= 1'b0;
            state_q      <= ST_HALTED;
            bp_hit_q     <= '0;
            steps_q      <= '0;
            retire_cnt_q <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            db_level_q   <= db_level_d;
            db_cnt_q     <= db_cnt_d;
            db_prev_q    <= db_prev_d;
            state_q      <= state_d;
            bp_hit_q     <= bp_hit_d;
            steps_q      <= steps_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign o_pipe_en    = pipe_en;
    assign o_halted     = (state_q == ST_HALTED) & (i_mode != MODE_FREE);
    assign o_bp_hit     = bp_hit_q;
    assign o_steps_left = steps_q;
    assign o_retire_cnt = retire_cnt_q;

endmodule
